// File: rtl/riscv_fetch.sv
// ---------------------------------------------------------------------------
// riscv_fetch
//
// Instruction-fetch stage of the RV32I single-cycle core. It owns the program
// counter, requests each instruction from instruction memory with a
// request/acknowledge handshake, and holds the fetched word stable until the
// execute logic has consumed it. After consumption it picks the next PC as
// one of PC+4, PC+imm or (rs1+imm) with bit 0 cleared. A target whose bit 1
// is set halts fetch with a sticky exception. Retired instructions are
// counted, including the jump or branch that raises the exception.
//
// Ports
//   i_clk, i_rstn        clock (rising edge), asynchronous active-low reset
//   i_fetch_src_pc       next-PC select: 0 PC+4, 1 PC+imm, 2 rs1+imm, 3 PC+4
//   i_fetch_imm          sign-extended immediate from decode
//   i_fetch_rs1_data     rs1 read data, used by JALR
//   i_fetch_ready        execute consumes the current instruction this cycle
//   o_imem_req/addr      instruction-memory request and its address
//   i_imem_ack/rdata     memory acknowledge and the instruction word
//   o_fetch_valid        o_fetch_instr holds a valid instruction
//   o_fetch_instr        fetched instruction (registered)
//   o_fetch_pc/pc4       PC of the current instruction and PC+4
//   o_fetch_exc          sticky misaligned-target exception
//   o_fetch_badaddr      offending target address
//   o_fetch_instret      retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [1:0]  i_fetch_src_pc,
    input  logic [31:0] i_fetch_imm,
    input  logic [31:0] i_fetch_rs1_data,
    input  logic        i_fetch_ready,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_fetch_valid,
    output logic [31:0] o_fetch_instr,
    output logic [31:0] o_fetch_pc,
    output logic [31:0] o_fetch_pc4,
    output logic        o_fetch_exc,
    output logic [31:0] o_fetch_badaddr,
    output logic [31:0] o_fetch_instret
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    // Instructions are 4-byte aligned. JALR has already cleared bit 0, so
    // only bit 1 can make a target misaligned.
    function automatic logic target_misaligned(input logic [31:0] addr);
        return addr[1];
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        exc_q, exc_d;
    logic [31:0] badaddr_q, badaddr_d;
    logic [31:0] instret_q, instret_d;
    logic        imem_req_q;
    logic        fetch_valid_q;

    logic [31:0] pc_plus4_s;
    logic [31:0] jalr_sum_s;
    logic [31:0] next_pc_s;

    // Next-PC selection from the control unit's source select.
    always_comb begin
        pc_plus4_s = pc_q + 32'd4;
        jalr_sum_s = i_fetch_rs1_data + i_fetch_imm;
        next_pc_s  = pc_plus4_s;
        case (i_fetch_src_pc)
            2'd0:    next_pc_s = pc_plus4_s;
            2'd1:    next_pc_s = pc_q + i_fetch_imm;
            2'd2:    next_pc_s = jalr_sum_s & 32'hFFFF_FFFE;
            default: next_pc_s = pc_plus4_s;
        endcase
    end

    // Fetch FSM next-state logic and datapath updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        exc_d     = exc_q;
        badaddr_d = badaddr_q;
        instret_d = instret_q;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_REQ;
            end
            ST_REQ: begin
                // The acknowledge is honoured only here; anywhere else it is
                // treated as noise.
                if (i_imem_ack) begin
                    instr_d = i_imem_rdata;
                    state_d = ST_VALID;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_VALID: begin
                if (i_fetch_ready) begin
                    instret_d = instret_q + 32'd1;
                    if (target_misaligned(next_pc_s)) begin
                        // The jump itself retires, but the PC stays on it so
                        // the faulting instruction remains identifiable.
                        exc_d     = 1'b1;
                        badaddr_d = next_pc_s;
                        state_d   = ST_HALT;
                    end else begin
                        pc_d    = next_pc_s;
                        state_d = ST_REQ;
                    end
                end else begin
                    state_d = ST_VALID;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, datapath registers and the handshake flags. The flags are
    // registered copies of the next-state decode, so they depend on state
    // only and never combinationally on the acknowledge input.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= NOP_INSTR;
            exc_q         <= 1'b0;
            badaddr_q     <= 32'h0000_0000;
            instret_q     <= 32'h0000_0000;
            imem_req_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            exc_q         <= exc_d;
            badaddr_q     <= badaddr_d;
            instret_q     <= instret_d;
            imem_req_q    <= (state_d == ST_REQ);
            fetch_valid_q <= (state_d == ST_VALID);
        end
    end

    assign o_imem_req      = imem_req_q;
    assign o_imem_addr     = pc_q;
    assign o_fetch_valid   = fetch_valid_q;
    assign o_fetch_instr   = instr_q;
    assign o_fetch_pc      = pc_q;
    assign o_fetch_pc4     = pc_plus4_s;
    assign o_fetch_exc     = exc_q;
    assign o_fetch_badaddr = badaddr_q;
    assign o_fetch_instret = instret_q;

endmodule

// File: tb/tb_riscv_fetch.sv
// ---------------------------------------------------------------------------
// tb_riscv_fetch
//
// Drives riscv_fetch with a behavioural memory (random wait states and data)
// and a behavioural execute stage (random next-PC selects). An architectural
// model tracks the PC, the retire count and the halt condition. Each
// acknowledged fetch pushes the expected instruction into a queue. A monitor
// pops an entry whenever o_fetch_valid rises and compares it with the DUT.
// ---------------------------------------------------------------------------
module tb_riscv_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [1:0]  i_fetch_src_pc;
    logic [31:0] i_fetch_imm;
    logic [31:0] i_fetch_rs1_data;
    logic        i_fetch_ready;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ack;
    logic [31:0] i_imem_rdata;
    logic        o_fetch_valid;
    logic [31:0] o_fetch_instr;
    logic [31:0] o_fetch_pc;
    logic [31:0] o_fetch_pc4;
    logic        o_fetch_exc;
    logic [31:0] o_fetch_badaddr;
    logic [31:0] o_fetch_instret;

    riscv_fetch #(.RESET_PC(RESET_PC)) dut (
        .i_clk            (i_clk),
        .i_rstn           (i_rstn),
        .i_fetch_src_pc   (i_fetch_src_pc),
        .i_fetch_imm      (i_fetch_imm),
        .i_fetch_rs1_data (i_fetch_rs1_data),
        .i_fetch_ready    (i_fetch_ready),
        .o_imem_req       (o_imem_req),
        .o_imem_addr      (o_imem_addr),
        .i_imem_ack       (i_imem_ack),
        .i_imem_rdata     (i_imem_rdata),
        .o_fetch_valid    (o_fetch_valid),
        .o_fetch_instr    (o_fetch_instr),
        .o_fetch_pc       (o_fetch_pc),
        .o_fetch_pc4      (o_fetch_pc4),
        .o_fetch_exc      (o_fetch_exc),
        .o_fetch_badaddr  (o_fetch_badaddr),
        .o_fetch_instret  (o_fetch_instret)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] instret;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Architectural model state
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    bit          m_halted;
    logic [31:0] m_badaddr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Apply reset (asynchronous effect is checked straight away), then
    // release it and confirm the first request follows one BOOT cycle.
    task automatic do_reset();
        i_rstn = 1'b0;
        #1;
        check("rst_req_async", 32'(o_imem_req), 32'd0);
        check("rst_valid_async", 32'(o_fetch_valid), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_pc", o_fetch_pc, RESET_PC);
        check("rst_instr", o_fetch_instr, 32'h0000_0013);
        check("rst_exc", 32'(o_fetch_exc), 32'd0);
        check("rst_badaddr", o_fetch_badaddr, 32'd0);
        check("rst_instret", o_fetch_instret, 32'd0);
        i_imem_ack    = 1'b1;  // a stray ack in BOOT must be ignored
        i_fetch_ready = 1'b1;
        i_rstn        = 1'b1;
        m_pc      = RESET_PC;
        m_instret = 32'd0;
        m_halted  = 1'b0;
        exp_q.delete();
        tick();
        i_imem_ack    = 1'b0;
        i_fetch_ready = 1'b0;
        check("boot_first_req", 32'(o_imem_req), 32'd1);
        check("boot_valid_low", 32'(o_fetch_valid), 32'd0);
    endtask

    // Behavioural memory: wait for the request, hold off for wait_n cycles
    // with junk data, then acknowledge with the real word.
    task automatic fetch_one(input int wait_n, input logic [31:0] word);
        int k;
        k = 0;
        while (!o_imem_req && k < 20) begin
            tick();
            k++;
        end
        check("req_seen", 32'(o_imem_req), 32'd1);
        check("req_addr", o_imem_addr, m_pc);
        for (int w = 0; w < wait_n; w++) begin
            i_imem_ack    = 1'b0;
            i_imem_rdata  = $urandom;
            i_fetch_ready = 1'($urandom);
            tick();
            check("wait_addr_stable", o_imem_addr, m_pc);
            check("wait_valid_low", 32'(o_fetch_valid), 32'd0);
        end
        i_imem_ack   = 1'b1;
        i_imem_rdata = word;
        exp_q.push_back('{pc: m_pc, instr: word, instret: m_instret});
        tick();
        i_imem_ack    = 1'b0;
        i_imem_rdata  = $urandom;
        i_fetch_ready = 1'b0;
    endtask

    // Behavioural execute stage plus the architectural next-PC rule.
    task automatic retire(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] rs1);
        int          k;
        logic [31:0] target;
        k = 0;
        while (!o_fetch_valid && k < 20) begin
            tick();
            k++;
        end
        check("valid_seen", 32'(o_fetch_valid), 32'd1);
        i_fetch_src_pc   = src;
        i_fetch_imm      = imm;
        i_fetch_rs1_data = rs1;
        i_fetch_ready    = 1'b1;
        i_imem_ack       = 1'($urandom);  // must be ignored outside REQ
        i_imem_rdata     = $urandom;
        if (src == 2'd1)      target = m_pc + imm;
        else if (src == 2'd2) target = (rs1 + imm) & ~32'd1;
        else                  target = m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        if (target % 4 != 0) begin
            m_halted  = 1'b1;
            m_badaddr = target;
        end else begin
            m_pc = target;
        end
        tick();
        i_fetch_ready = 1'b0;
        i_imem_ack    = 1'b0;
        i_fetch_src_pc   = $urandom;
        i_fetch_imm      = $urandom;
        i_fetch_rs1_data = $urandom;
        if (m_halted) begin
            for (int h = 0; h < 4; h++) begin
                check("halt_req_low", 32'(o_imem_req), 32'd0);
                check("halt_valid_low", 32'(o_fetch_valid), 32'd0);
                check("halt_exc", 32'(o_fetch_exc), 32'd1);
                check("halt_badaddr", o_fetch_badaddr, m_badaddr);
                check("halt_instret", o_fetch_instret, m_instret);
                check("halt_pc", o_fetch_pc, m_pc);
                i_fetch_ready = 1'($urandom);
                i_imem_ack    = 1'($urandom);
                tick();
            end
            i_fetch_ready = 1'b0;
            i_imem_ack    = 1'b0;
        end
    endtask

    // Step one instruction: fetch, then retire with an aligned random target.
    task automatic random_step();
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] t;
        fetch_one($urandom_range(0, 3), $urandom);
        src = 2'($urandom);
        rs1 = $urandom;
        imm = $urandom & 32'hFFFF_FFFC;
        if (src == 2'd2) begin
            t   = $urandom & 32'hFFFF_FFFC;
            imm = t - rs1 + ($urandom & 32'd1);
        end
        retire(src, imm, rs1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev_valid;
        i_rstn           = 1'b1;
        i_fetch_src_pc   = 2'd0;
        i_fetch_imm      = 32'd0;
        i_fetch_rs1_data = 32'd0;
        i_fetch_ready    = 1'b0;
        i_imem_ack       = 1'b0;
        i_imem_rdata     = 32'd0;
        m_pc      = RESET_PC;
        m_instret = 32'd0;
        m_halted  = 1'b0;
        m_badaddr = 32'd0;
        prev_valid = 1'b0;

        fork
            // Monitor: compare each newly presented instruction with the
            // scoreboard head.
            forever begin
                exp_t e;
                @(negedge i_clk);
                if (o_fetch_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL mon_unexpected_valid: actual pc %h expected no instruction", o_fetch_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("mon_instr", o_fetch_instr, e.instr);
                        check("mon_pc", o_fetch_pc, e.pc);
                        check("mon_pc4", o_fetch_pc4, e.pc + 32'd4);
                        check("mon_instret", o_fetch_instret, e.instret);
                        check("mon_req_low", 32'(o_imem_req), 32'd0);
                    end
                end
                prev_valid = o_fetch_valid;
            end
        join_none

        // Reset and the first zero-wait fetch of a NOP
        do_reset();
        fetch_one(0, 32'h0000_0013);

        // Sequential execution: 0x0, 0x4, 0x8, 0xC
        for (int i = 0; i < 3; i++) begin
            retire(2'd0, $urandom, $urandom);
            fetch_one(0, $urandom);
        end
        check("seq_instret", o_fetch_instret, 32'd3);
        retire(2'd3, $urandom, $urandom);  // 0xC -> 0x10

        // Branch backwards, JAL forward, aligned JALR
        fetch_one(1, $urandom);
        retire(2'd1, 32'hFFFF_FFF8, $urandom);   // 0x10 -> 0x08
        fetch_one(0, $urandom);
        retire(2'd1, 32'h0000_0100, $urandom);   // 0x08 -> 0x108
        fetch_one(2, $urandom);
        retire(2'd2, 32'h0000_0003, 32'h0000_0101); // -> 0x104
        fetch_one(3, 32'hDEAD_BEEF);             // wait states with junk data

        // Randomised sequence
        retire(2'd0, 32'd0, 32'd0);
        for (int i = 0; i < 25; i++) begin
            random_step();
        end

        // PC wrap: jump to 0xFFFF_FFFC, then PC+4 wraps to 0
        fetch_one(0, $urandom);
        retire(2'd2, 32'd0, 32'hFFFF_FFFC);
        fetch_one(0, $urandom);
        retire(2'd0, $urandom, $urandom);
        fetch_one(0, $urandom);

        // Misaligned JALR target halts fetch
        retire(2'd2, 32'h0000_0001, 32'h0000_0101); // -> 0x102

        // Reset out of HALT clears the exception and counter
        do_reset();
        fetch_one(0, $urandom);
        retire(2'd1, 32'h0000_0040, $urandom);

        // Reset asserted while a request is outstanding, with an ack pending
        check("req_before_reset", 32'(o_imem_req), 32'd1);
        i_imem_ack = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            random_step();
        end
        fetch_one(0, $urandom);
        retire(2'd1, 32'h0000_0006, $urandom); // pc+6 is misaligned

        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
